// File: rtl/dvi_pkg.sv
// Default VGA 640x480@60 timing constants and shared types for the DVI timing generator.
package dvi_pkg;

    localparam int DEF_H_ACTIVE = 640;
    localparam int DEF_H_FP     = 16;
    localparam int DEF_H_SYNC   = 96;
    localparam int DEF_H_BP     = 48;
    localparam int DEF_V_ACTIVE = 480;
    localparam int DEF_V_FP     = 10;
    localparam int DEF_V_SYNC   = 2;
    localparam int DEF_V_BP     = 33;

    localparam int DEF_H_TOTAL = DEF_H_ACTIVE + DEF_H_FP + DEF_H_SYNC + DEF_H_BP;
    localparam int DEF_V_TOTAL = DEF_V_ACTIVE + DEF_V_FP + DEF_V_SYNC + DEF_V_BP;

    localparam int X_POS_W = 10;
    localparam int Y_POS_W = 10;

    typedef struct packed {
        logic hsync;
        logic vsync;
        logic de;
    } sync_t;

    // Blanking-level bundle: both syncs at their inactive level, de low.
    function automatic sync_t idle_sync(input bit pol);
        return '{hsync: ~pol, vsync: ~pol, de: 1'b0};
    endfunction

endpackage

// File: rtl/dvi_timing_gen_if.sv
// Video timing bundle: raster position, delayed sync/de and line/frame start pulses.
interface dvi_timing_gen_if;
    import dvi_pkg::*;

    logic [X_POS_W-1:0] x_o;
    logic [Y_POS_W-1:0] y_o;
    logic               hsync_o;
    logic               vsync_o;
    logic               de_o;
    logic               line_start_o;
    logic               frame_start_o;

    modport master (
        output x_o, y_o, hsync_o, vsync_o, de_o, line_start_o, frame_start_o
    );

    modport slave (
        input x_o, y_o, hsync_o, vsync_o, de_o, line_start_o, frame_start_o
    );

endinterface

// File: rtl/dvi_delay_line.sv
// Fixed-depth register delay line with asynchronous reset to a programmable idle value.
module dvi_delay_line #(
    parameter int               WIDTH   = 1,
    parameter int               DEPTH   = 1,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    if (DEPTH < 1) begin : g_bad_depth
        $error("dvi_delay_line: DEPTH must be at least 1");
    end

    logic [WIDTH-1:0] r_stage [DEPTH];

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            for (int i = 0; i < DEPTH; i++) r_stage[i] <= RST_VAL;
        end else begin
            r_stage[0] <= i_d;
            for (int i = 1; i < DEPTH; i++) r_stage[i] <= r_stage[i-1];
        end
    end

    assign o_q = r_stage[DEPTH-1];

endmodule

// File: rtl/dvi_timing_gen.sv
// Raster timing generator: x/y counters, line/frame pulses, and sync/de delayed to match pixel latency.
module dvi_timing_gen
    import dvi_pkg::*;
#(
    parameter int H_ACTIVE = DEF_H_ACTIVE,
    parameter int H_FP     = DEF_H_FP,
    parameter int H_SYNC   = DEF_H_SYNC,
    parameter int H_BP     = DEF_H_BP,
    parameter int V_ACTIVE = DEF_V_ACTIVE,
    parameter int V_FP     = DEF_V_FP,
    parameter int V_SYNC   = DEF_V_SYNC,
    parameter int V_BP     = DEF_V_BP,
    parameter bit SYNC_POL = 1'b0,
    parameter int PIPE_DLY = 2
) (
    input  logic             clk_i,
    input  logic             rst_i,
    dvi_timing_gen_if.master vid
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HS_BEG  = H_ACTIVE + H_FP;
    localparam int HS_END  = HS_BEG + H_SYNC;
    localparam int VS_BEG  = V_ACTIVE + V_FP;
    localparam int VS_END  = VS_BEG + V_SYNC;
    localparam sync_t SYNC_IDLE = idle_sync(SYNC_POL);

    if (H_TOTAL > (1 << X_POS_W)) begin : g_bad_h
        $error("dvi_timing_gen: H_TOTAL does not fit in X_POS_W bits");
    end
    if (V_TOTAL > (1 << Y_POS_W)) begin : g_bad_v
        $error("dvi_timing_gen: V_TOTAL does not fit in Y_POS_W bits");
    end
    if (PIPE_DLY < 0 || PIPE_DLY > 7) begin : g_bad_dly
        $error("dvi_timing_gen: PIPE_DLY must be in 0..7");
    end

    logic               r_run;
    logic [X_POS_W-1:0] r_x, w_x_nxt;
    logic [Y_POS_W-1:0] r_y, w_y_nxt;
    logic               r_line_start, r_frame_start;
    sync_t              w_raw_nxt;
    logic [2:0]         w_sync_dly;

    // r_run holds the raster at 0,0 for the first edge after reset so that position is shown.
    always_comb begin
        w_x_nxt = '0;
        w_y_nxt = '0;
        if (r_run) begin
            w_y_nxt = r_y;
            if (r_x == X_POS_W'(H_TOTAL - 1)) begin
                w_y_nxt = (r_y == Y_POS_W'(V_TOTAL - 1)) ? '0 : r_y + Y_POS_W'(1);
            end else begin
                w_x_nxt = r_x + X_POS_W'(1);
            end
        end
    end

    always_comb begin
        w_raw_nxt       = SYNC_IDLE;
        w_raw_nxt.de    = (w_x_nxt < X_POS_W'(H_ACTIVE)) && (w_y_nxt < Y_POS_W'(V_ACTIVE));
        if (w_x_nxt >= X_POS_W'(HS_BEG) && w_x_nxt < X_POS_W'(HS_END)) w_raw_nxt.hsync = SYNC_POL;
        if (w_y_nxt >= Y_POS_W'(VS_BEG) && w_y_nxt < Y_POS_W'(VS_END)) w_raw_nxt.vsync = SYNC_POL;
    end

    // Stage p0: counters and pulses registered together with the first sync/de stage.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_run         <= 1'b0;
            r_x           <= '0;
            r_y           <= '0;
            r_line_start  <= 1'b0;
            r_frame_start <= 1'b0;
        end else begin
            r_run         <= 1'b1;
            r_x           <= w_x_nxt;
            r_y           <= w_y_nxt;
            r_line_start  <= (w_x_nxt == '0);
            r_frame_start <= (w_x_nxt == '0) && (w_y_nxt == '0);
        end
    end

    // One register aligns sync/de with x/y; PIPE_DLY more add the pixel-path latency.
    dvi_delay_line #(
        .WIDTH   (3),
        .DEPTH   (PIPE_DLY + 1),
        .RST_VAL (SYNC_IDLE)
    ) u_sync_dly (
        .i_clk (clk_i),
        .i_rst (rst_i),
        .i_d   (w_raw_nxt),
        .o_q   (w_sync_dly)
    );

    assign vid.x_o           = r_x;
    assign vid.y_o           = r_y;
    assign vid.line_start_o  = r_line_start;
    assign vid.frame_start_o = r_frame_start;
    assign {vid.hsync_o, vid.vsync_o, vid.de_o} = w_sync_dly;

endmodule

// File: tb/tb_dvi_timing_gen.sv
// Scoreboard bench: three generator configurations, expected events queued, monitors pop on observed events.
module tb_dvi_timing_gen;
    import dvi_pkg::*;

    typedef struct {
        string tag;
        int    val;
    } exp_t;

    logic clk   = 1'b0;
    logic rst_a = 1'b1;
    logic rst_b = 1'b1;
    logic rst_c = 1'b1;

    always #5 clk = ~clk;

    dvi_timing_gen_if ifa ();
    dvi_timing_gen_if ifb ();
    dvi_timing_gen_if ifc ();

    // A: default timing, active-low sync, two-clock delay.
    dvi_timing_gen #(.SYNC_POL(1'b0), .PIPE_DLY(2)) u_a (
        .clk_i (clk), .rst_i (rst_a), .vid (ifa)
    );

    // B: tiny 16x8 raster so whole frames and the wrap corner fit in the run.
    dvi_timing_gen #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
        .SYNC_POL(1'b0), .PIPE_DLY(2)
    ) u_b (
        .clk_i (clk), .rst_i (rst_b), .vid (ifb)
    );

    // C: default timing, active-high sync, no extra delay.
    dvi_timing_gen #(.SYNC_POL(1'b1), .PIPE_DLY(0)) u_c (
        .clk_i (clk), .rst_i (rst_c), .vid (ifc)
    );

    int   n_cmp = 0;
    int   n_bad = 0;
    exp_t q_a[$];
    exp_t q_b[$];
    exp_t q_c[$];

    function automatic void check(string name, int act, int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endfunction

    function automatic void push(int id, string tag, int val);
        exp_t e;
        e.tag = tag;
        e.val = val;
        case (id)
            0:       q_a.push_back(e);
            1:       q_b.push_back(e);
            default: q_c.push_back(e);
        endcase
    endfunction

    function automatic void sb_obs(int id, string tag, int act);
        exp_t e;
        int   sz;
        sz = (id == 0) ? q_a.size() : (id == 1) ? q_b.size() : q_c.size();
        if (sz == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL dut%0d %s: got %0d, expected no further event", id, tag, act);
            return;
        end
        case (id)
            0:       e = q_a.pop_front();
            1:       e = q_b.pop_front();
            default: e = q_c.pop_front();
        endcase
        if (e.tag != tag) begin
            n_cmp++;
            n_bad++;
            $display("FAIL dut%0d order: got %s=%0d, expected %s=%0d", id, tag, act, e.tag, e.val);
        end else begin
            check($sformatf("dut%0d %s", id, tag), act, e.val);
        end
    endfunction

    // Monitor A: fixed-cycle samples plus de/hsync edge events.
    int   a_cyc = 0, a_lc = 0, a_rise = 0, a_hs_beg = 0;
    logic a_de_q = 1'b0, a_hs_q = 1'b1;
    initial forever begin
        @(negedge clk);
        if (rst_a) begin
            a_cyc = 0; a_lc = 0; a_de_q = 1'b0; a_hs_q = 1'b1;
        end else begin
            if (a_cyc == 0) begin
                sb_obs(0, "x0",  int'(ifa.x_o));
                sb_obs(0, "y0",  int'(ifa.y_o));
                sb_obs(0, "fs0", int'(ifa.frame_start_o));
            end
            if (a_cyc == 799) sb_obs(0, "x799", int'(ifa.x_o));
            if (a_cyc == 800) begin
                sb_obs(0, "x800",  int'(ifa.x_o));
                sb_obs(0, "y800",  int'(ifa.y_o));
                sb_obs(0, "ls800", int'(ifa.line_start_o));
            end
            a_lc = ifa.line_start_o ? 0 : a_lc + 1;
            if (ifa.de_o && !a_de_q) begin sb_obs(0, "de_rise", a_lc); a_rise = a_cyc; end
            if (!ifa.de_o && a_de_q) sb_obs(0, "de_len", a_cyc - a_rise);
            if (!ifa.hsync_o && a_hs_q) begin sb_obs(0, "hs_x", int'(ifa.x_o)); a_hs_beg = a_cyc; end
            if (ifa.hsync_o && !a_hs_q) sb_obs(0, "hs_len", a_cyc - a_hs_beg);
            a_de_q = ifa.de_o;
            a_hs_q = ifa.hsync_o;
            a_cyc++;
        end
    end

    // Monitor B: restart state, frame period, vsync width, wrap corner, blanking de.
    int   b_cyc = 0, b_fs_cyc = 0, b_vs_beg = 0, b_px = 0, b_py = 0;
    int   b_ymax = 0, b_deviol = 0;
    logic b_first = 1'b1, b_have_fs = 1'b0, b_vs_q = 1'b1;
    initial forever begin
        @(negedge clk);
        if (rst_b) begin
            b_cyc = 0; b_first = 1'b1; b_have_fs = 1'b0; b_vs_q = 1'b1; b_px = 0; b_py = 0;
        end else begin
            if (b_first) sb_obs(1, "rel", int'(ifb.x_o) * 1000 + int'(ifb.y_o) * 100 +
                                          int'(ifb.frame_start_o) * 10 + int'(ifb.line_start_o));
            b_first = 1'b0;
            if (b_px == 15 && b_py == 7)
                sb_obs(1, "wrap", int'(ifb.x_o) * 100 + int'(ifb.y_o) * 10 + int'(ifb.frame_start_o));
            if (ifb.frame_start_o) begin
                if (b_have_fs) sb_obs(1, "fs_per", b_cyc - b_fs_cyc);
                b_have_fs = 1'b1;
                b_fs_cyc  = b_cyc;
            end
            if (!ifb.vsync_o && b_vs_q) b_vs_beg = b_cyc;
            if (ifb.vsync_o && !b_vs_q) sb_obs(1, "vs_len", b_cyc - b_vs_beg);
            if (ifb.de_o && int'(ifb.y_o) >= 4) b_deviol++;
            if (int'(ifb.y_o) > b_ymax) b_ymax = int'(ifb.y_o);
            b_px   = int'(ifb.x_o);
            b_py   = int'(ifb.y_o);
            b_vs_q = ifb.vsync_o;
            b_cyc++;
        end
    end

    // Monitor C: same-cycle active-high sync against raster position.
    int   c_cyc = 0, c_hs_beg = 0, c_hsmis = 0, c_vsmis = 0, c_demis = 0;
    logic c_first = 1'b1, c_hs_q = 1'b0;
    initial forever begin
        @(negedge clk);
        if (rst_c) begin
            c_cyc = 0; c_first = 1'b1; c_hs_q = 1'b0;
        end else begin
            if (c_first) sb_obs(2, "rel", int'(ifc.x_o) * 1000 + int'(ifc.y_o) * 100 +
                                          int'(ifc.frame_start_o) * 10 + int'(ifc.line_start_o));
            c_first = 1'b0;
            if (ifc.hsync_o != (ifc.x_o >= 10'd656 && ifc.x_o < 10'd752)) c_hsmis++;
            if (ifc.vsync_o != (ifc.y_o >= 10'd490 && ifc.y_o < 10'd492)) c_vsmis++;
            if (ifc.de_o != (ifc.x_o < 10'd640 && ifc.y_o < 10'd480)) c_demis++;
            if (ifc.hsync_o && !c_hs_q) begin sb_obs(2, "hs_x", int'(ifc.x_o)); c_hs_beg = c_cyc; end
            if (!ifc.hsync_o && c_hs_q) sb_obs(2, "hs_len", c_cyc - c_hs_beg);
            c_hs_q = ifc.hsync_o;
            c_cyc++;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete within the time limit");
        $fatal(1, "watchdog");
    end

    int hits;

    initial begin
        repeat (3) @(negedge clk);
        check("a_rst_x",  int'(ifa.x_o), 0);
        check("a_rst_y",  int'(ifa.y_o), 0);
        check("a_rst_de", int'(ifa.de_o), 0);
        check("a_rst_hs", int'(ifa.hsync_o), 1);
        check("a_rst_vs", int'(ifa.vsync_o), 1);
        check("a_rst_ls", int'(ifa.line_start_o), 0);
        check("a_rst_fs", int'(ifa.frame_start_o), 0);
        check("b_rst_hs", int'(ifb.hsync_o), 1);
        check("c_rst_hs", int'(ifc.hsync_o), 0);
        check("c_rst_vs", int'(ifc.vsync_o), 0);
        check("c_rst_de", int'(ifc.de_o), 0);

        push(0, "x0", 0); push(0, "y0", 0); push(0, "fs0", 1);
        for (int l = 0; l < 3; l++) begin
            if (l == 1) begin
                push(0, "x799", 799);
                push(0, "x800", 0); push(0, "y800", 1); push(0, "ls800", 1);
            end
            push(0, "de_rise", 2); push(0, "de_len", 640);
            push(0, "hs_x", 658);  push(0, "hs_len", 96);
        end
        push(1, "rel", 11);
        for (int f = 0; f < 2; f++) begin
            push(1, "vs_len", 32); push(1, "wrap", 1); push(1, "fs_per", 128);
        end
        push(2, "rel", 11);
        for (int l = 0; l < 3; l++) begin
            push(2, "hs_x", 656); push(2, "hs_len", 96);
        end

        #2;
        rst_a = 1'b0; rst_b = 1'b0; rst_c = 1'b0;

        // Third visit of x=13,y=5 on B: both syncs are active at its output here.
        hits = 0;
        for (int i = 0; i < 600 && hits < 3; i++) begin
            @(negedge clk);
            if (ifb.x_o == 10'd13 && ifb.y_o == 10'd5) hits++;
        end
        check("b_sync_point_reached", hits, 3);
        if (hits == 3) begin
            check("b_pre_hs", int'(ifb.hsync_o), 0);
            check("b_pre_vs", int'(ifb.vsync_o), 0);
            #1 rst_b = 1'b1;
            #1;
            check("b_async_hs", int'(ifb.hsync_o), 1);
            check("b_async_vs", int'(ifb.vsync_o), 1);
            check("b_async_de", int'(ifb.de_o), 0);
            check("b_async_x",  int'(ifb.x_o), 0);
            check("b_async_y",  int'(ifb.y_o), 0);
            push(1, "rel", 11); push(1, "vs_len", 32); push(1, "wrap", 1); push(1, "fs_per", 128);
            @(negedge clk);
            #2 rst_b = 1'b0;
            for (int i = 0; i < 300 && b_cyc < 135; i++) @(negedge clk);
            check("b_restart_run", int'(b_cyc >= 135), 1);
            rst_b = 1'b1;
        end

        for (int i = 0; i < 3000 && a_cyc < 2380; i++) @(negedge clk);
        check("a_run_len", int'(a_cyc >= 2380), 1);

        check("a_events_left", q_a.size(), 0);
        check("b_events_left", q_b.size(), 0);
        check("c_events_left", q_c.size(), 0);
        check("b_de_in_vblank", b_deviol, 0);
        check("b_y_max", b_ymax, 7);
        check("c_hs_position", c_hsmis, 0);
        check("c_vs_position", c_vsmis, 0);
        check("c_de_position", c_demis, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
